// File: rtl/float8_dot_accumulator.sv
// Float8 dot-product accumulator: sums a stream of Float8 products plus a bias
// in exact signed fixed point, then normalises and truncates the sum to one Float8 result.
module float8_dot_accumulator #(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned ACC_W   = 20 + $clog2(MAX_LEN)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [LEN_W-1:0] iLen,
  input  logic [7:0]       iBias,
  input  logic             iProdValid,
  input  logic [7:0]       iProd,
  input  logic             iProdOvf,
  output logic             oProdReady,
  output logic             oBusy,
  output logic             oValid,
  input  logic             iResultReady,
  output logic [7:0]       oResult,
  output logic             oOverflow
);

  localparam int unsigned LEAD_W = $clog2(ACC_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] NORM  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             sticky;
  logic             ovf_sign;

  logic             accept;
  logic             acc_neg;
  logic [ACC_W-1:0] acc_abs;
  logic [LEAD_W-1:0] lead;
  logic [3:0]       norm_exp;
  logic [2:0]       norm_mant;
  logic [7:0]       norm_result;
  logic             norm_ovf;

  // Exact Float8 to fixed-point conversion (LSB weight 2^-10), two's complement.
  function automatic logic [ACC_W-1:0] fix8(input logic [7:0] f);
    logic [ACC_W-1:0] mag;
    mag = ACC_W'({1'b1, f[2:0]}) << f[6:3];
    if (f[6:0] == 7'd0) begin
      mag = '0;
    end
    return f[7] ? (~mag + ACC_W'(1)) : mag;
  endfunction

  assign accept = iProdValid && (state == ACCUM);

  // State register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (iStart) state_n = (iLen == '0) ? NORM : ACCUM;
      ACCUM:   if (accept && (cnt == LEN_W'(1))) state_n = NORM;
      NORM:    state_n = DONE;
      DONE:    if (iResultReady) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Normalise |acc| into a truncated Float8 with saturation and flush-to-zero.
  always_comb begin
    acc_neg = acc[ACC_W-1];
    acc_abs = acc_neg ? (~acc + ACC_W'(1)) : acc;
    lead    = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (acc_abs[i]) lead = LEAD_W'(i);
    end
    norm_exp  = 4'(lead - LEAD_W'(3));
    norm_mant = 3'(acc_abs >> (lead - LEAD_W'(3)));
    norm_result = {acc_neg, norm_exp, norm_mant};
    norm_ovf    = 1'b0;
    if (sticky) begin
      norm_result = {ovf_sign, 7'h7F};
      norm_ovf    = 1'b1;
    end else if (lead < LEAD_W'(3)) begin
      norm_result = 8'h00;
    end else if (lead > LEAD_W'(18)) begin
      norm_result = {acc_neg, 7'h7F};
      norm_ovf    = 1'b1;
    end
  end

  // Accumulator, product counter and overflow tracking.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      acc      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      ovf_sign <= 1'b0;
    end else if ((state == IDLE) && iStart) begin
      acc      <= fix8(iBias);
      cnt      <= iLen;
      sticky   <= 1'b0;
      ovf_sign <= 1'b0;
    end else if (accept) begin
      cnt <= cnt - LEN_W'(1);
      if (iProdOvf) begin
        sticky <= 1'b1;
        if (!sticky) ovf_sign <= iProd[7];
      end else begin
        acc <= acc + fix8(iProd);
      end
    end
  end

  // Registered handshake/status outputs follow the upcoming state; result captured in NORM.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oProdReady <= 1'b0;
      oBusy      <= 1'b0;
      oValid     <= 1'b0;
      oResult    <= 8'h00;
      oOverflow  <= 1'b0;
    end else begin
      oProdReady <= (state_n == ACCUM);
      oBusy      <= (state_n != IDLE);
      oValid     <= (state_n == DONE);
      if (state == NORM) begin
        oResult   <= norm_result;
        oOverflow <= norm_ovf;
      end
    end
  end

endmodule
